// File: rtl/phase_countdown_timer.sv
// Phase countdown timer: prescaled down-counter with load/start/pause FSM.
// Define PHASE_TIMER_BCD_EN to add registered BCD outputs of count.
module phase_countdown_timer #(
  parameter int pCNT_WIDTH    = 7,
  parameter int pCLK_PER_TICK = 50000000,
  parameter int pDEFAULT_LOAD = 99,
  parameter int pWARN_THRESH  = 3
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_load,
  input  logic [pCNT_WIDTH-1:0] i_load_value,
  input  logic                  i_start,
  input  logic                  i_pause,
  input  logic                  i_auto_reload,
  output logic [pCNT_WIDTH-1:0] o_count,
  output logic                  o_tick,
  output logic                  o_done,
  output logic                  o_running,
  output logic                  o_last,
  output logic                  o_pre_last,
`ifdef PHASE_TIMER_BCD_EN
  output logic [3:0]            o_bcd_tens,
  output logic [3:0]            o_bcd_ones,
`endif
  output logic                  o_warn
);

  localparam int PW = (pCLK_PER_TICK > 1) ? $clog2(pCLK_PER_TICK) : 1;
  localparam logic [PW-1:0] PS_MAX = PW'(pCLK_PER_TICK - 1);
  localparam logic [pCNT_WIDTH-1:0] DEF_LOAD = pCNT_WIDTH'(pDEFAULT_LOAD);
  localparam logic [pCNT_WIDTH-1:0] WARN_TH = pCNT_WIDTH'(pWARN_THRESH);
  localparam logic [pCNT_WIDTH-1:0] ONE = pCNT_WIDTH'(1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_RUN     = 2'd1;
  localparam logic [1:0] S_PAUSED  = 2'd2;
  localparam logic [1:0] S_EXPIRED = 2'd3;

  logic [1:0]            r_state;
  logic [pCNT_WIDTH-1:0] r_count;
  logic [pCNT_WIDTH-1:0] r_reload;
  logic [PW-1:0]         r_presc;
  logic                  r_tick;
  logic                  r_done;

  logic w_cnt_zero;
  logic w_presc_wrap;

  assign w_cnt_zero   = (r_count == '0);
  assign w_presc_wrap = (r_presc == PS_MAX);

  always_ff @(posedge i_clk) begin
    r_tick <= 1'b0;
    r_done <= 1'b0;
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_count  <= DEF_LOAD;
      r_reload <= DEF_LOAD;
      r_presc  <= '0;
    end else if (i_load) begin
      r_count  <= i_load_value;
      r_reload <= i_load_value;
      r_presc  <= '0;
      r_state  <= i_start ? S_RUN : S_IDLE;
    end else if (i_start) begin
      // From IDLE the loaded count is kept; otherwise restart from reload.
      r_presc <= '0;
      r_state <= S_RUN;
      if (r_state != S_IDLE) begin
        r_count <= r_reload;
      end
    end else begin
      case (r_state)
        S_RUN: begin
          if (i_pause) begin
            r_state <= S_PAUSED;
          end else if (w_presc_wrap) begin
            r_presc <= '0;
            r_tick  <= 1'b1;
            if (!w_cnt_zero) begin
              r_count <= r_count - ONE;
            end else begin
              r_done <= 1'b1;
              if (i_auto_reload) begin
                r_count <= r_reload;
              end else begin
                r_state <= S_EXPIRED;
              end
            end
          end else begin
            r_presc <= r_presc + PW'(1);
          end
        end
        S_PAUSED: begin
          if (!i_pause) begin
            r_state <= S_RUN;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign o_count    = r_count;
  assign o_tick     = r_tick;
  assign o_done     = r_done;
  assign o_running  = (r_state == S_RUN);
  assign o_last     = w_cnt_zero;
  assign o_pre_last = (r_count == ONE);
  assign o_warn     = !w_cnt_zero && (r_count <= WARN_TH);

`ifdef PHASE_TIMER_BCD_EN
  logic [31:0] w_cnt32;
  logic [3:0]  r_bcd_tens;
  logic [3:0]  r_bcd_ones;

  assign w_cnt32 = 32'(r_count);

  // Counts above two digits saturate the display at 99.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_bcd_tens <= 4'd0;
      r_bcd_ones <= 4'd0;
    end else if (w_cnt32 > 32'd99) begin
      r_bcd_tens <= 4'd9;
      r_bcd_ones <= 4'd9;
    end else begin
      r_bcd_tens <= 4'(w_cnt32 / 32'd10);
      r_bcd_ones <= 4'(w_cnt32 % 32'd10);
    end
  end

  assign o_bcd_tens = r_bcd_tens;
  assign o_bcd_ones = r_bcd_ones;
`endif

endmodule

// File: doc/phase_countdown_timer.md
Name: phase_countdown_timer

Overview:
Parametrised successor to the fixed 0..99 second down-counter used by the traffic-light phase logic. It has these additions:
- built-in tick prescaler;
- runtime-loadable phase duration;
- start/pause control through an explicit FSM;
- optional auto-reload;
- configurable warning window;
- registered done pulse.

It sits between the phase controller FSM, which loads and starts it, and the display/lamp drivers, which consume count, last, pre_last and warn.

Parameters:
pCNT_WIDTH, 7, width of count and load_value.
pCLK_PER_TICK, 50000000, clk cycles per count tick (≥1); prescaler width = $clog2(pCLK_PER_TICK), minimum 1.
pDEFAULT_LOAD, 99, reset value of count and reload register; must fit pCNT_WIDTH.
pWARN_THRESH, 3, warn asserted while 1 ≤ count ≤ pWARN_THRESH.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  synchronous active-high reset.
load  in  1  load_value → count and reload register.
load_value  in  pCNT_WIDTH  phase duration in ticks.
start  in  1  pulse; begin/restart countdown.
pause  in  1  level; freeze countdown while high.
auto_reload  in  1  level; at expiry reload from reload register and keep running.
count  out  pCNT_WIDTH  remaining ticks (registered).
tick  out  1  1-cycle pulse on each count tick (RUN only).
done  out  1  1-cycle registered pulse at expiry.
running  out  1  state == RUN.
last  out  1  count == 0.
pre_last  out  1  count == 1.
warn  out  1  1 ≤ count ≤ pWARN_THRESH.

Behaviour:
- All state updates on posedge clk. rst dominates everything.
- Reset values:
  - count = reload = pDEFAULT_LOAD;
  - prescaler = 0;
  - state = IDLE;
  - tick = done = 0.
- States: IDLE, RUN, PAUSED, EXPIRED.
- Priority per cycle: rst > load > start > pause > tick processing.
- load in any state:
  - count and reload ← load_value; prescaler ← 0.
  - Next state is RUN if start is high in the same cycle, otherwise IDLE.
- start (load low):
  - IDLE → RUN, count unchanged, prescaler ← 0.
  - EXPIRED → RUN, count ← reload, prescaler ← 0.
  - RUN/PAUSED: restart; count ← reload, prescaler ← 0, state RUN.
- Pause: RUN with pause=1 → PAUSED; prescaler and count hold. PAUSED with pause=0 → RUN; prescaler resumes from its held value.
- Prescaler:
  - Increments only in RUN.
  - On reaching pCLK_PER_TICK-1 it wraps to 0, and tick is registered high for the following cycle.
  - count updates in that same edge.
- Tick action in RUN:
  - count > 0: count ← count-1.
  - count == 0, auto_reload=1: count ← reload, done=1, stay RUN.
  - count == 0, auto_reload=0: count holds 0, done=1, state → EXPIRED.
- Phase length from start to done is (N+1)×pCLK_PER_TICK cycles for a loaded value N. count shows N..0.
- load_value 0: the first tick after start produces done.
- EXPIRED holds count=0 until load or start.
- last, pre_last, warn and running are combinational decodes of the registers, so they have zero extra latency relative to count.
- done and tick are never asserted outside the cycle after a tick edge. A load or start in the cycle of a would-be tick suppresses that tick and done.
- pause asserted in the same cycle as the tick edge: the tick is not taken, because pause has priority.
- No arithmetic overflow: count only decrements from ≥1 or reloads.

Optional Feature:
PHASE_TIMER_BCD_EN:
- Defined: adds outputs bcd_tens[3:0] and bcd_ones[3:0], registered, reset 0. Each cycle they are computed from count with one cycle of latency. count > 99 saturates to 9/9.
- Undefined: ports and logic are absent; other behaviour is identical.

Test Plan:
- Test parameters for all scenarios: pCLK_PER_TICK=4, pDEFAULT_LOAD=5, pWARN_THRESH=2.
- Scenario 1: rst, then start → count 5,4,3,2,1,0 stepping every 4 cycles; warn high at 2,1; pre_last at 1; done pulses once 4 cycles after count hits 0; state EXPIRED, count stays 0.
- Scenario 2: load_value=3 with start in the same cycle → next cycle count=3 and running=1; done arrives after 16 cycles.
- Scenario 3: RUN at count=4, prescaler=2; pause for 10 cycles → count stays 4 and tick stays low; after release, the next tick comes 2 cycles later and count=3.
- Scenario 4: auto_reload=1, load 2 then start → count 2,1,0,2,1,0…; done pulses every 12 cycles; running stays 1.
- Scenario 5: rst asserted mid-RUN at count=1 → next cycle count=5, IDLE, done=0, tick=0. start asserted in the same cycle as a pending tick → restart wins, count=reload, no done.
- Scenario 6 (PHASE_TIMER_BCD_EN defined, pCNT_WIDTH=7): load 47 → bcd 4/7 one cycle after count; load 120 → bcd 9/9.
